axil_timer_irq: RTL and testbench



---
 rtl/axil_timer_irq_pkg.sv | 35 +++
 rtl/axil_timer_irq_core.sv | 82 ++++++++
 rtl/axil_timer_irq.sv | 128 ++++++++++++
 tb/tb_axil_timer_irq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_timer_irq_pkg.sv
// Shared definitions for the AXI-Lite timer peripheral: response codes,
// register word indices (byte address bits [4:2]) and CTRL bit positions.
`timescale 1ns / 1ps
package axil_timer_irq_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_IE         = 1;
  localparam int CTRL_AUTORELOAD = 2;

  // Indices 5..7 (offsets 0x14-0x1C) are holes in the map.
  function automatic logic reg_idx_valid(input logic [2:0] idx);
    return idx <= REG_PRESCALE;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_timer_irq_core.sv
// Timer datapath: prescaler, 32-bit up-counter, compare match, sticky pending
// flag and registered interrupt, behind a simple write-strobe/readback port.
`timescale 1ns / 1ps
module axil_timer_irq_core
  import axil_timer_irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_idx,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [2:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [2:0]  ctrl;
  logic        pending;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] prescale;
  logic [31:0] pre_cnt;

  logic wr_ctrl, wr_status, wr_count, wr_compare, wr_prescale;
  logic tick, match;

  always_comb begin
    wr_ctrl     = wr_en && (wr_idx == REG_CTRL);
    wr_status   = wr_en && (wr_idx == REG_STATUS);
    wr_count    = wr_en && (wr_idx == REG_COUNT);
    wr_compare  = wr_en && (wr_idx == REG_COMPARE);
    wr_prescale = wr_en && (wr_idx == REG_PRESCALE);
    tick        = ctrl[CTRL_EN] && (pre_cnt == prescale);
    // A software write to COUNT on a tick edge also cancels that edge's match.
    match       = tick && (count == compare) && !wr_count;
  end

  // NOTE: every flop uses <= so all updates see the pre-edge register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      pending  <= 1'b0;
      count    <= '0;
      compare  <= '0;
      prescale <= '0;
      pre_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl && wr_strb[0]) ctrl <= wr_data[2:0];
      if (wr_compare)  compare  <= apply_strb(compare, wr_data, wr_strb);
      if (wr_prescale) prescale <= apply_strb(prescale, wr_data, wr_strb);

      if (wr_prescale || !ctrl[CTRL_EN] || tick) pre_cnt <= '0;
      else                                       pre_cnt <= pre_cnt + 32'd1;

      if (wr_count)                            count <= apply_strb(count, wr_data, wr_strb);
      else if (match && ctrl[CTRL_AUTORELOAD]) count <= '0;
      else if (tick)                           count <= count + 32'd1;

      // Hardware set beats a same-edge W1C so no match is ever lost.
      if (match)                                        pending <= 1'b1;
      else if (wr_status && wr_strb[0] && wr_data[0])   pending <= 1'b0;

      irq <= pending & ctrl[CTRL_IE];
    end
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    rd_data = '0;
    case (rd_idx)
      REG_CTRL:     rd_data = {29'd0, ctrl};
      REG_STATUS:   rd_data = {31'd0, pending};
      REG_COUNT:    rd_data = count;
      REG_COMPARE:  rd_data = compare;
      REG_PRESCALE: rd_data = prescale;
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: rtl/axil_timer_irq.sv
// AXI-Lite responder for the timer: independent AW/W holding registers, one
// outstanding B and one outstanding R, all handshake outputs registered.
`timescale 1ns / 1ps
module axil_timer_irq
  import axil_timer_irq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  irq
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("axil_timer_irq supports DATA_WIDTH = 32 only");
  end

  logic        aw_full, w_full;
  logic [2:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_hs, w_hs, ar_hs, do_write, wr_err, rd_err;
  logic        aw_full_nxt, w_full_nxt, rvalid_nxt;
  logic [31:0] core_rd;

  // Only address bits [4:2] are decoded; protection bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                       s_axil_araddr[ADDR_WIDTH-1:5], s_axil_araddr[1:0]};

  always_comb begin
    aw_hs    = s_axil_awvalid && s_axil_awready;
    w_hs     = s_axil_wvalid && s_axil_wready;
    ar_hs    = s_axil_arvalid && s_axil_arready;
    do_write = aw_full && w_full && !s_axil_bvalid;
    wr_err   = !reg_idx_valid(aw_idx);
    rd_err   = !reg_idx_valid(s_axil_araddr[4:2]);

    aw_full_nxt = aw_full;
    if (aw_hs)         aw_full_nxt = 1'b1;
    else if (do_write) aw_full_nxt = 1'b0;

    w_full_nxt = w_full;
    if (w_hs)          w_full_nxt = 1'b1;
    else if (do_write) w_full_nxt = 1'b0;

    rvalid_nxt = s_axil_rvalid;
    if (ar_hs)              rvalid_nxt = 1'b1;
    else if (s_axil_rready) rvalid_nxt = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      aw_idx         <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= AXIL_RESP_OKAY;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rresp   <= AXIL_RESP_OKAY;
      s_axil_rdata   <= '0;
    end else begin
      aw_full        <= aw_full_nxt;
      w_full         <= w_full_nxt;
      s_axil_awready <= !aw_full_nxt;
      s_axil_wready  <= !w_full_nxt;
      if (aw_hs) aw_idx <= s_axil_awaddr[4:2];
      if (w_hs) begin
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end

      if (do_write) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end

      s_axil_rvalid  <= rvalid_nxt;
      s_axil_arready <= !rvalid_nxt;
      if (ar_hs) begin
        s_axil_rdata <= core_rd;
        s_axil_rresp <= rd_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
      end
    end
  end

  axil_timer_irq_core u_core (
    .clk     (aclk),
    .rst_n   (aresetn),
    .wr_en   (do_write && !wr_err),
    .wr_idx  (aw_idx),
    .wr_data (w_data),
    .wr_strb (w_strb),
    .rd_idx  (s_axil_araddr[4:2]),
    .rd_data (core_rd),
    .irq     (irq)
  );

endmodule

// File: tb/tb_axil_timer_irq.sv
// Directed and randomized bench for axil_timer_irq; timer results are predicted
// from enabled-cycle counts with plain arithmetic.
`timescale 1ns / 1ps
module tb_axil_timer_irq;

  localparam logic [31:0] A_CTRL     = 32'h00;
  localparam logic [31:0] A_STATUS   = 32'h04;
  localparam logic [31:0] A_COUNT    = 32'h08;
  localparam logic [31:0] A_COMPARE  = 32'h0C;
  localparam logic [31:0] A_PRESCALE = 32'h10;
  localparam logic [1:0]  OKAY       = 2'b00;
  localparam logic [1:0]  SLVERR     = 2'b10;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [31:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  axil_timer_irq dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .irq            (irq)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Timer outcome after n enabled edges from COUNT=c0, with a fresh prescaler.
  function automatic void timer_model(input int c0, input int cmp, input int p, input int n,
                                      input bit au, output int cnt, output bit pend);
    int ticks, to_match;
    ticks    = n / (p + 1);
    to_match = cmp - c0 + 1;
    if (c0 <= cmp && ticks >= to_match) begin
      pend = 1'b1;
      cnt  = au ? (ticks - to_match) % (cmp + 1) : c0 + ticks;
    end else begin
      pend = 1'b0;
      cnt  = c0 + ticks;
    end
  endfunction

  // Called at a negedge. Returns the edge index on which the register was written.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output int edge_idx);
    int  n;
    bit  aw_go, w_go;
    n = 0;
    s_axil_awaddr  = addr;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = data;
    s_axil_wstrb   = strb;
    s_axil_wvalid  = 1'b1;
    while ((s_axil_awvalid || s_axil_wvalid) && n < 50) begin
      aw_go = s_axil_awvalid && s_axil_awready;
      w_go  = s_axil_wvalid && s_axil_wready;
      @(negedge aclk);
      n++;
      if (aw_go) s_axil_awvalid = 1'b0;
      if (w_go)  s_axil_wvalid  = 1'b0;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    while (!s_axil_bvalid && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check("bvalid_seen", s_axil_bvalid, 1);
    resp     = s_axil_bresp;
    edge_idx = cyc;
    if (s_axil_bready) @(negedge aclk);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    while (!got && n < 50) begin
      got = s_axil_arready;
      @(negedge aclk);
      n++;
    end
    s_axil_arvalid = 1'b0;
    check("rvalid_latency", s_axil_rvalid, 1);
    data = s_axil_rdata;
    resp = s_axil_rresp;
    @(negedge aclk);
  endtask

  initial begin
    logic [31:0] rd, base, pdata, exp_v, hi;
    logic [1:0]  rsp;
    logic [3:0]  pstrb;
    int          e1, e2, e_w, c0, cmp, p, wt, exp_cnt;
    bit          au, ie, exp_pend, stable;

    aresetn        = 1'b0;
    s_axil_awaddr  = '0;
    s_axil_awprot  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b1;
    s_axil_araddr  = '0;
    s_axil_arprot  = '0;
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b1;

    // Reset state and ready release
    repeat (3) @(negedge aclk);
    check("reset_outputs", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp,
                            s_axil_arready, s_axil_rvalid, s_axil_rresp, irq}, 0);
    check("reset_rdata", s_axil_rdata, 0);
    aresetn = 1'b1;
    #1;
    check("ready_at_release", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    @(negedge aclk);
    check("ready_after_edge", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);
    axi_read(A_COUNT, rd, rsp);
    check("reset_count", rd, 0);
    check("reset_count_resp", rsp, OKAY);

    // W leads AW by three cycles
    s_axil_wdata  = 32'h10;
    s_axil_wstrb  = 4'hF;
    s_axil_wvalid = 1'b1;
    @(negedge aclk);
    s_axil_wvalid = 1'b0;
    check("wready_held", s_axil_wready, 0);
    repeat (2) @(negedge aclk);
    s_axil_awaddr  = A_COMPARE;
    s_axil_awvalid = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0;
    check("b_not_yet", s_axil_bvalid, 0);
    @(negedge aclk);
    check("b_after_aw", s_axil_bvalid, 1);
    check("b_after_aw_resp", s_axil_bresp, OKAY);
    @(negedge aclk);
    axi_read(A_COMPARE, rd, rsp);
    check("compare_rb", rd, 32'h10);

    // PRESCALE=3, COMPARE=5, autoreload with interrupt
    axi_write(A_PRESCALE, 32'd3, 4'hF, rsp, e_w);
    axi_write(A_COMPARE, 32'd5, 4'hF, rsp, e_w);
    axi_write(A_CTRL, 32'h7, 4'hF, rsp, e1);
    while (cyc < e1 + 24) @(negedge aclk);
    check("irq_before_match", irq, 0);
    @(negedge aclk);
    check("irq_after_match", irq, 1);
    axi_write(A_CTRL, 32'h6, 4'hF, rsp, e2);
    timer_model(0, 5, 3, e2 - e1, 1'b1, exp_cnt, exp_pend);
    axi_read(A_COUNT, rd, rsp);
    check("t3_count", rd, exp_cnt);
    axi_read(A_STATUS, rd, rsp);
    check("t3_pending", rd, 1);
    axi_write(A_STATUS, 32'h1, 4'hF, rsp, e_w);
    check("t3_irq_cleared", irq, 0);

    // W1C in the match cycle loses to the match
    axi_write(A_CTRL, 32'h0, 4'hF, rsp, e_w);
    axi_write(A_COUNT, 32'h0, 4'hF, rsp, e_w);
    axi_write(A_PRESCALE, 32'h0, 4'hF, rsp, e_w);
    axi_write(A_CTRL, 32'h1, 4'hF, rsp, e1);
    repeat (3) @(negedge aclk);
    axi_write(A_STATUS, 32'h1, 4'hF, rsp, e_w);
    check("w1c_edge", e_w, e1 + 6);
    axi_read(A_STATUS, rd, rsp);
    check("w1c_loses", rd, 1);

    // COUNT write on a matching tick wins and suppresses the match
    axi_write(A_CTRL, 32'h0, 4'hF, rsp, e_w);
    axi_write(A_STATUS, 32'h1, 4'hF, rsp, e_w);
    axi_write(A_COUNT, 32'h0, 4'hF, rsp, e_w);
    axi_write(A_CTRL, 32'h1, 4'hF, rsp, e1);
    repeat (3) @(negedge aclk);
    axi_write(A_COUNT, 32'h1234, 4'hF, rsp, e_w);
    check("cnt_wr_edge", e_w, e1 + 6);
    axi_write(A_CTRL, 32'h0, 4'hF, rsp, e2);
    axi_read(A_COUNT, rd, rsp);
    check("cnt_wr_wins", rd, 32'h1234 + (e2 - e_w));
    axi_read(A_STATUS, rd, rsp);
    check("match_suppressed", rd, 0);

    // B back-pressure with a second write queued
    s_axil_bready = 1'b0;
    axi_write(A_COMPARE, 32'hAA, 4'hF, rsp, e_w);
    stable = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      if (!(s_axil_bvalid === 1'b1 && s_axil_bresp === OKAY)) stable = 1'b0;
    end
    check("b_stable", stable, 1);
    s_axil_awaddr  = A_COMPARE;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = 32'hBB;
    s_axil_wstrb   = 4'hF;
    s_axil_wvalid  = 1'b1;
    @(negedge aclk);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    check("awready_full", s_axil_awready, 0);
    check("wready_full", s_axil_wready, 0);
    axi_read(A_COMPARE, rd, rsp);
    check("second_held", rd, 32'hAA);
    s_axil_bready = 1'b1;
    @(negedge aclk);
    check("first_b_gone", s_axil_bvalid, 0);
    @(negedge aclk);
    check("second_b", s_axil_bvalid, 1);
    @(negedge aclk);
    axi_read(A_COMPARE, rd, rsp);
    check("second_written", rd, 32'hBB);
    check("awready_back", s_axil_awready, 1);

    // Holes in the map
    axi_write(A_CTRL, 32'h2, 4'hF, rsp, e_w);
    axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, rsp, e_w);
    check("hole_wr_resp", rsp, SLVERR);
    axi_read(32'h1C, rd, rsp);
    check("hole_rd_resp", rsp, SLVERR);
    check("hole_rd_data", rd, 0);
    axi_read(A_COMPARE, rd, rsp);
    check("hole_no_cmp_change", rd, 32'hBB);
    axi_read(A_CTRL, rd, rsp);
    check("hole_no_ctrl_change", rd, 32'h2);

    // Randomized timer runs and byte-strobe merges
    for (int t = 0; t < 6; t++) begin
      hi    = $urandom & 32'hFFFF_FFE0;
      base  = $urandom;
      pdata = $urandom;
      pstrb = 4'($urandom);
      axi_write(hi | A_COMPARE, base, 4'hF, rsp, e_w);
      axi_write(hi | A_COMPARE, pdata, pstrb, rsp, e_w);
      exp_v = base;
      for (int b = 0; b < 4; b++) if (pstrb[b]) exp_v[b*8 +: 8] = pdata[b*8 +: 8];
      axi_read(hi | A_COMPARE, rd, rsp);
      check("strb_merge", rd, exp_v);

      c0  = $urandom_range(0, 4);
      cmp = $urandom_range(0, 12);
      p   = $urandom_range(0, 3);
      wt  = $urandom_range(5, 60);
      au  = 1'($urandom);
      ie  = 1'($urandom);
      axi_write(A_COUNT, c0, 4'hF, rsp, e_w);
      axi_write(A_COMPARE, cmp, 4'hF, rsp, e_w);
      axi_write(hi | A_PRESCALE, p, 4'hF, rsp, e_w);
      axi_write(A_STATUS, 32'h1, 4'hF, rsp, e_w);
      axi_write(A_CTRL, {29'd0, au, ie, 1'b1}, 4'hF, rsp, e1);
      repeat (wt) @(negedge aclk);
      axi_write(hi | A_CTRL, {29'd0, au, ie, 1'b0}, 4'hF, rsp, e2);
      timer_model(c0, cmp, p, e2 - e1, au, exp_cnt, exp_pend);
      axi_read(hi | A_COUNT, rd, rsp);
      check("rand_count", rd, exp_cnt);
      axi_read(A_STATUS, rd, rsp);
      check("rand_pending", rd, {31'd0, exp_pend});
      check("rand_irq", irq, exp_pend & ie);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
